// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL phase sequencer.
// State codes, phase width and phasecounterselect encodings.
package pll_seq_pkg;

  localparam int PHASE_W = 8;

  localparam logic [2:0] CS_ALL = 3'b000;
  localparam logic [2:0] CS_M   = 3'b001;
  localparam logic [2:0] CS_C0  = 3'b010;
  localparam logic [2:0] CS_C1  = 3'b011;
  localparam logic [2:0] CS_C2  = 3'b100;
  localparam logic [2:0] CS_C3  = 3'b101;
  localparam logic [2:0] CS_C4  = 3'b110;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CHKSRC = 4'd1;
  localparam logic [3:0] ST_SWITCH = 4'd2;
  localparam logic [3:0] ST_SETTLE = 4'd3;
  localparam logic [3:0] ST_CALC   = 4'd4;
  localparam logic [3:0] ST_ARM    = 4'd5;
  localparam logic [3:0] ST_HOLD   = 4'd6;
  localparam logic [3:0] ST_WAITLO = 4'd7;
  localparam logic [3:0] ST_WAITHI = 4'd8;

endpackage

// File: rtl/pll_phase_sequencer_scanclk.sv
// Free-running scanclk divider with one-cycle edge strobes.
// Strobes are high in the clk cycle right after the scanclk edge.
module pll_scanclk_gen #(
  parameter int SCAN_HALF = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_scanclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(SCAN_HALF + 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_rise;
  logic          r_fall;
  logic          w_tick;

  assign w_tick = (r_cnt == CW'(SCAN_HALF - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_tick & ~r_sclk;
      r_fall <= w_tick & r_sclk;
      if (w_tick) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_scanclk = r_sclk;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;

endmodule

// File: rtl/pll_phase_sequencer.sv
// PLL request sequencer: clock switch plus shortest-path phase
// stepping with a one-deep last-wins request queue.
module pll_phase_sequencer
  import pll_seq_pkg::*;
#(
  parameter int         PHASE_STEPS = 64,
  parameter int         SCAN_HALF   = 4,
  parameter int         SWITCH_CYC  = 8,
  parameter int         SETTLE_CYC  = 1000,
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [2:0] CNT_SEL     = CS_ALL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               updatepll,
  input  logic               pll_clk_src,
  input  logic [PHASE_W-1:0] pll_clk_phase,
  input  logic               phasedone,
  output logic [2:0]         phasecounterselect,
  output logic               phaseupdown,
  output logic               phasestep,
  output logic               scanclk,
  output logic               clkswitch,
  output logic               busy,
  output logic [PHASE_W-1:0] cur_phase,
  output logic               cur_src,
  output logic               err
);

  localparam int CW = 16;

  logic [3:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_pend_v;
  logic               r_pend_src;
  logic [PHASE_W-1:0] r_pend_ph;
  logic               r_tgt_src;
  logic [PHASE_W-1:0] r_tgt;
  logic [PHASE_W-1:0] r_cur_phase;
  logic               r_cur_src;
  logic [8:0]         r_steps;
  logic               r_updown;
  logic               r_step;
  logic               r_clkswitch;
  logic               r_err;
  logic               r_pd_meta;
  logic               r_pd_sync;

  logic               w_rise;
  logic               w_fall;
  logic               w_req_ok;
  logic [8:0]         w_up;
  logic [8:0]         w_dn;
  logic               w_go_up;
  logic [PHASE_W-1:0] w_next;
  logic               w_to;

  pll_scanclk_gen #(.SCAN_HALF(SCAN_HALF)) u_sclk (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .o_scanclk(scanclk),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_req_ok = (32'(pll_clk_phase) < 32'(PHASE_STEPS));

  // Distance going up, modulo the period; the other way round is the rest.
  assign w_up = (r_tgt >= r_cur_phase)
              ? ({1'b0, r_tgt} - {1'b0, r_cur_phase})
              : (9'(PHASE_STEPS) + {1'b0, r_tgt} - {1'b0, r_cur_phase});
  assign w_dn    = 9'(PHASE_STEPS) - w_up;
  assign w_go_up = (w_up <= w_dn);

  always_comb begin
    w_next = r_cur_phase;
    if (r_updown) begin
      if (r_cur_phase == PHASE_W'(PHASE_STEPS - 1)) w_next = '0;
      else w_next = r_cur_phase + 1'b1;
    end else begin
      if (r_cur_phase == '0) w_next = PHASE_W'(PHASE_STEPS - 1);
      else w_next = r_cur_phase - 1'b1;
    end
  end

  assign w_to = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pd_meta <= 1'b1;
      r_pd_sync <= 1'b1;
    end else begin
      r_pd_meta <= phasedone;
      r_pd_sync <= r_pd_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_v   <= 1'b0;
      r_pend_src <= 1'b0;
      r_pend_ph  <= '0;
    end else if (updatepll && w_req_ok) begin
      r_pend_v   <= 1'b1;
      r_pend_src <= pll_clk_src;
      r_pend_ph  <= pll_clk_phase;
    end else if (r_state == ST_IDLE && r_pend_v) begin
      r_pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tgt_src   <= 1'b0;
      r_tgt       <= '0;
      r_cur_phase <= '0;
      r_cur_src   <= 1'b0;
      r_steps     <= '0;
      r_updown    <= 1'b1;
      r_step      <= 1'b0;
      r_clkswitch <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend_v) begin
            r_tgt_src <= r_pend_src;
            r_tgt     <= r_pend_ph;
            r_err     <= 1'b0;
            r_state   <= ST_CHKSRC;
          end
        end
        ST_CHKSRC: begin
          if (r_tgt_src != r_cur_src) begin
            r_clkswitch <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_SWITCH;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_SWITCH: begin
          if (r_cnt == CW'(SWITCH_CYC - 1)) begin
            r_clkswitch <= 1'b0;
            r_cur_src   <= r_tgt_src;
            r_cnt       <= '0;
            r_state     <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CW'(SETTLE_CYC - 1)) r_state <= ST_CALC;
          else r_cnt <= r_cnt + 1'b1;
        end
        ST_CALC: begin
          if (w_up == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_updown <= w_go_up;
            r_steps  <= w_go_up ? w_up : w_dn;
            r_state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_fall) begin
            r_step  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_rise) begin
            if (r_cnt == CW'(1)) begin
              r_cnt   <= '0;
              r_state <= ST_WAITLO;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WAITLO: begin
          if (!r_pd_sync) begin
            r_step  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_WAITHI;
          end else if (w_to) begin
            r_err   <= 1'b1;
            r_step  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAITHI: begin
          if (r_pd_sync) begin
            r_cur_phase <= w_next;
            r_steps     <= r_steps - 1'b1;
            r_state     <= (r_steps == 9'd1) ? ST_IDLE : ST_ARM;
          end else if (w_to) begin
            r_err   <= 1'b1;
            r_step  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Out-of-range requests flag an error even mid-sequence.
      if (updatepll && !w_req_ok) r_err <= 1'b1;
    end
  end

  assign phasecounterselect = CNT_SEL;
  assign phaseupdown        = r_updown;
  assign phasestep          = r_step;
  assign clkswitch          = r_clkswitch;
  assign busy               = (r_state != ST_IDLE) | r_pend_v;
  assign cur_phase          = r_cur_phase;
  assign cur_src            = r_cur_src;
  assign err                = r_err;

endmodule
